// File: rtl/adpll_pkg.sv
// Shared ADPLL definitions: lock-state encodings, gain-shift width and the
// default datapath widths shared by the error combiner, loop filter and DCO.
package adpll_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKING  = 2'd1,
    LOCKED   = 2'd2
  } lock_state_t;

  localparam int GAIN_SHIFT_WIDTH = 3;
  localparam int ERROR_WIDTH_DEF  = 8;
  localparam int CTRL_WIDTH_DEF   = 12;
  localparam int FRAC_WIDTH_DEF   = 6;

endpackage

// File: rtl/sat_signed.sv
// Combinational signed clamp: narrows a signed value to OUT_WIDTH bits,
// clamping to the most positive/negative code instead of wrapping.
module sat_signed #(
  parameter int IN_WIDTH  = 13,
  parameter int OUT_WIDTH = 12
) (
  input  logic signed [IN_WIDTH-1:0]  value,
  output logic signed [OUT_WIDTH-1:0] clamped
);

  logic [IN_WIDTH-OUT_WIDTH:0] top_bits;

  // The value fits when every bit from the output sign bit upward agrees.
  always_comb begin
    top_bits = value[IN_WIDTH-1:OUT_WIDTH-1];
    clamped  = value[OUT_WIDTH-1:0];
    if (!((&top_bits) || !(|top_bits))) begin
      if (value[IN_WIDTH-1]) begin
        clamped = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      end else begin
        clamped = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      end
    end
  end

endmodule

// File: rtl/loop_filter_pi.sv
// ADPLL proportional-integral loop filter: saturating integrator plus shifted
// proportional path, two-stage registered DCO control word and lock detector.
module loop_filter_pi
  import adpll_pkg::*;
#(
  parameter int ERROR_WIDTH = ERROR_WIDTH_DEF,
  parameter int CTRL_WIDTH  = CTRL_WIDTH_DEF,
  parameter int FRAC_WIDTH  = FRAC_WIDTH_DEF,
  parameter int LOCK_THRESH = 2,
  parameter int LOCK_COUNT  = 16,
  parameter int CTRL_INIT   = 0
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic signed [ERROR_WIDTH-1:0] error_i,
  input  logic                          error_valid_i,
  input  logic [GAIN_SHIFT_WIDTH-1:0]   kp_shift_i,
  input  logic [GAIN_SHIFT_WIDTH-1:0]   ki_shift_i,
  input  logic                          freeze_i,
  output logic signed [CTRL_WIDTH-1:0]  ctrl_o,
  output logic                          ctrl_valid_o,
  output logic                          locked_o
);

  localparam int ACC_WIDTH  = CTRL_WIDTH + FRAC_WIDTH;
  localparam int PROP_WIDTH = CTRL_WIDTH + 8;
  localparam int CNT_WIDTH  = $clog2(LOCK_COUNT + 1);

  localparam logic signed [ACC_WIDTH-1:0]  INTEG_INIT = $signed(ACC_WIDTH'(CTRL_INIT)) <<< FRAC_WIDTH;
  localparam logic signed [CTRL_WIDTH-1:0] CTRL_RESET = CTRL_WIDTH'(CTRL_INIT);
  localparam logic [CNT_WIDTH-1:0]         COUNT_TARGET = CNT_WIDTH'(LOCK_COUNT);
  localparam logic [ERROR_WIDTH:0]         THRESH = (ERROR_WIDTH + 1)'(LOCK_THRESH);

  logic signed [ACC_WIDTH-1:0]  integ, err_acc, inc, integ_next;
  logic signed [ACC_WIDTH:0]    integ_sum;
  logic signed [PROP_WIDTH-1:0] prop, prop_q;
  logic signed [PROP_WIDTH:0]   out_sum;
  logic signed [CTRL_WIDTH-1:0] ctrl_next;
  logic                         s1_valid;

  logic signed [ERROR_WIDTH:0]  err_wide;
  logic [ERROR_WIDTH:0]         err_abs;
  logic                         in_window;
  lock_state_t                  state, state_next;
  logic [CNT_WIDTH-1:0]         count, count_next;

  // Sums are formed one bit wider than their registers so the clamps see true overflow.
  always_comb begin
    err_acc   = ACC_WIDTH'(error_i);
    inc       = (err_acc <<< FRAC_WIDTH) >>> ki_shift_i;
    integ_sum = (ACC_WIDTH + 1)'(integ) + (ACC_WIDTH + 1)'(inc);
    prop      = PROP_WIDTH'(error_i) <<< kp_shift_i;
    out_sum   = (PROP_WIDTH + 1)'(integ >>> FRAC_WIDTH) + (PROP_WIDTH + 1)'(prop_q);
  end

  sat_signed #(.IN_WIDTH(ACC_WIDTH + 1), .OUT_WIDTH(ACC_WIDTH)) u_sat_integ (
    .value   (integ_sum),
    .clamped (integ_next)
  );

  sat_signed #(.IN_WIDTH(PROP_WIDTH + 1), .OUT_WIDTH(CTRL_WIDTH)) u_sat_ctrl (
    .value   (out_sum),
    .clamped (ctrl_next)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      integ        <= INTEG_INIT;
      prop_q       <= '0;
      s1_valid     <= 1'b0;
      ctrl_o       <= CTRL_RESET;
      ctrl_valid_o <= 1'b0;
    end else begin
      s1_valid     <= error_valid_i;
      ctrl_valid_o <= s1_valid;
      if (error_valid_i) begin
        prop_q <= prop;
        if (!freeze_i) integ <= integ_next;
      end
      if (s1_valid) ctrl_o <= ctrl_next;
    end
  end

  // Magnitude needs one extra bit so the most negative error is not in-window.
  always_comb begin
    err_wide  = (ERROR_WIDTH + 1)'(error_i);
    err_abs   = err_wide[ERROR_WIDTH] ? $unsigned(-err_wide) : $unsigned(err_wide);
    in_window = (err_abs <= THRESH);
  end

  always_comb begin
    state_next = state;
    count_next = count;
    if (error_valid_i) begin
      if (!in_window) begin
        state_next = UNLOCKED;
        count_next = '0;
      end else begin
        case (state)
          UNLOCKED, LOCKING: begin
            count_next = (state == UNLOCKED) ? CNT_WIDTH'(1) : count + CNT_WIDTH'(1);
            state_next = (count_next >= COUNT_TARGET) ? LOCKED : LOCKING;
          end
          LOCKED: ;
          default: begin
            state_next = UNLOCKED;
            count_next = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state    <= UNLOCKED;
      count    <= '0;
      locked_o <= 1'b0;
    end else begin
      state    <= state_next;
      count    <= count_next;
      locked_o <= (state_next == LOCKED);
    end
  end

endmodule

// File: tb/tb_loop_filter_pi.sv
// Directed bench for loop_filter_pi: table of single/burst samples with
// hand-computed control words, plus lock-detector and async-reset sequences.
module tb_loop_filter_pi;

  typedef struct {
    bit    doReset;
    int    err;
    int    kp;
    int    ki;
    bit    frz;
    int    reps;
    int    expCtrl;
    bit    expLocked;
    string name;
  } vec_t;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic signed [7:0]  error = '0;
  logic               errorValid = 1'b0;
  logic [2:0]         kpShift = '0;
  logic [2:0]         kiShift = '0;
  logic               freeze = 1'b0;
  logic signed [11:0] ctrl;
  logic               ctrlValid;
  logic               locked;

  int checks = 0;
  int errors = 0;
  vec_t vecs[14];

  loop_filter_pi dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .error_i       (error),
    .error_valid_i (errorValid),
    .kp_shift_i    (kpShift),
    .ki_shift_i    (kiShift),
    .freeze_i      (freeze),
    .ctrl_o        (ctrl),
    .ctrl_valid_o  (ctrlValid),
    .locked_o      (locked)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic doReset();
    errorValid = 1'b0;
    reset = 1'b1;
    #3;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  // Drives reps back-to-back valid samples; returns 1 time unit after the last stage-1 edge.
  task automatic applyStimulus(input int err, input int kp, input int ki, input bit frz,
                               input int reps, input string name);
    for (int i = 0; i < reps; i++) begin
      error      = 8'(err);
      kpShift    = 3'(kp);
      kiShift    = 3'(ki);
      freeze     = frz;
      errorValid = 1'b1;
      @(posedge clk); #1;
    end
    errorValid = 1'b0;
    freeze     = 1'b0;
    if (reps == 1) checkVal({name, " no pulse at stage 1"}, int'(ctrlValid), 0);
  endtask

  task automatic checkOutput(input string name, input int expCtrl, input bit expLocked);
    @(posedge clk); #1;
    checkVal({name, " valid pulse"}, int'(ctrlValid), 1);
    checkVal({name, " ctrl"}, int'(ctrl), expCtrl);
    checkVal({name, " locked"}, int'(locked), int'(expLocked));
    @(posedge clk); #1;
    checkVal({name, " pulse end"}, int'(ctrlValid), 0);
    checkVal({name, " ctrl hold"}, int'(ctrl), expCtrl);
  endtask

  task automatic sendLock(input int err);
    error      = 8'(err);
    kpShift    = '0;
    kiShift    = '0;
    freeze     = 1'b0;
    errorValid = 1'b1;
    @(posedge clk); #1;
    errorValid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    vecs[0]  = '{1'b1,    4, 0, 0, 1'b0,  1,     8, 1'b0, "p+i basic"};
    vecs[1]  = '{1'b0,    0, 0, 0, 1'b0,  1,     4, 1'b0, "integ only"};
    vecs[2]  = '{1'b1,    1, 7, 6, 1'b0,  1,   128, 1'b0, "ki6 kp7"};
    vecs[3]  = '{1'b0,   -1, 0, 6, 1'b0,  1,    -1, 1'b0, "ki6 negative"};
    vecs[4]  = '{1'b0,    0, 0, 0, 1'b0,  1,     0, 1'b0, "floor cancels"};
    vecs[5]  = '{1'b1,  127, 0, 0, 1'b0, 20,  2047, 1'b0, "pos saturation"};
    vecs[6]  = '{1'b0,   -1, 0, 0, 1'b0,  1,  2045, 1'b0, "pos unwind"};
    vecs[7]  = '{1'b0,    0, 0, 0, 1'b0,  1,  2046, 1'b0, "integ after unwind"};
    vecs[8]  = '{1'b1, -128, 0, 0, 1'b0, 20, -2048, 1'b0, "neg saturation"};
    vecs[9]  = '{1'b0,    1, 0, 0, 1'b0,  1, -2046, 1'b0, "neg unwind"};
    vecs[10] = '{1'b1,  100, 0, 0, 1'b0,  1,   200, 1'b0, "preload 100"};
    vecs[11] = '{1'b0,   10, 0, 0, 1'b1,  5,   110, 1'b0, "freeze"};
    vecs[12] = '{1'b0,    0, 0, 0, 1'b0,  1,   100, 1'b0, "freeze release"};
    vecs[13] = '{1'b1,   -3, 2, 0, 1'b0,  1,   -15, 1'b0, "negative prop"};

    #3;
    checkVal("reset ctrl", int'(ctrl), 0);
    checkVal("reset ctrl_valid", int'(ctrlValid), 0);
    checkVal("reset locked", int'(locked), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      if (vecs[i].doReset) doReset();
      applyStimulus(vecs[i].err, vecs[i].kp, vecs[i].ki, vecs[i].frz, vecs[i].reps, vecs[i].name);
      checkOutput(vecs[i].name, vecs[i].expCtrl, vecs[i].expLocked);
    end

    // Lock detector with idle gaps between samples
    doReset();
    for (int i = 0; i < 15; i++) begin
      sendLock(1);
      idle(1);
    end
    checkVal("lock after 15", int'(locked), 0);
    sendLock(1);
    checkVal("lock at 16th edge", int'(locked), 1);
    idle(3);
    checkVal("lock held while idle", int'(locked), 1);
    sendLock(3);
    checkVal("unlock on error 3", int'(locked), 0);

    // Threshold boundary and most-negative error
    doReset();
    for (int i = 0; i < 15; i++) begin
      sendLock((i % 2 == 1) ? 2 : -2);
      idle(1);
    end
    sendLock(2);
    checkVal("lock with +-2 in window", int'(locked), 1);
    idle(1);
    sendLock(-128);
    checkVal("unlock on -128", int'(locked), 0);
    idle(1);
    for (int i = 0; i < 15; i++) begin
      sendLock(1);
      idle(1);
    end
    checkVal("relock count restarted", int'(locked), 0);
    sendLock(1);
    checkVal("relock at 16th", int'(locked), 1);
    idle(1);
    checkVal("ctrl before reset", int'(ctrl), -111);

    // Async reset between edges with a sample in stage 1
    sendLock(1);
    #2;
    reset = 1'b1;
    #1;
    checkVal("async reset ctrl", int'(ctrl), 0);
    checkVal("async reset ctrl_valid", int'(ctrlValid), 0);
    checkVal("async reset locked", int'(locked), 0);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkVal("no pulse after reset", int'(ctrlValid), 0);
    end
    checkVal("ctrl stays at init", int'(ctrl), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
